rr_arbiter: RTL

Parametrised N-way request arbiter with registered one-hot grant, a binary grant index, a valid flag and a per-grant hold limit. It succeeds the combinational 8-to-3 priority encoder: the same MSB-first fixed-priority mode is retained, and a fair round-robin mode with a rotating pointer is added. It sits in front of any shared resource (bus, memory port, output mux select) and drives a `mux_16to1`-style select directly from `grant_idx`.

---
 rtl/rr_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way request arbiter with registered one-hot grant, binary index and valid.
// Round-robin (rotating pointer) or MSB-first fixed priority, with an optional per-grant hold limit.
`default_nettype none

module rr_arbiter #(
  parameter int N         = 8,
  parameter int PRIO_MODE = 0,
  parameter int MAX_HOLD  = 4,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         valid
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 1) ? CW'(MAX_HOLD - 1) : '0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [W-1:0]  ptr;
  logic [CW-1:0] cnt;

  logic [W-1:0]  next_ptr;
  logic [W-1:0]  arb_ptr;
  logic [W-1:0]  win;
  logic [N-1:0]  win_oh;
  logic          found;
  logic          release_now;

  // While granting, arbitration only matters on release, where the pointer
  // has already moved past the current holder.
  always_comb begin : p_arb
    int scan;
    scan        = 0;
    next_ptr    = (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
    arb_ptr     = (state == GRANT) ? next_ptr : ptr;
    release_now = !req[grant_idx] || ((MAX_HOLD != 0) && (cnt == HOLD_LAST));
    found       = 1'b0;
    win         = '0;
    if (PRIO_MODE != 0) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          found = 1'b1;
          win   = W'(i);
        end
      end
    end else begin
      for (int off = 0; off < N; off++) begin
        scan = int'(arb_ptr) + off;
        if (scan >= N) scan = scan - N;
        if (!found && req[scan]) begin
          found = 1'b1;
          win   = W'(scan);
        end
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      valid     <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant     <= win_oh;
            grant_idx <= win;
            valid     <= 1'b1;
            cnt       <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            if (PRIO_MODE == 0) ptr <= next_ptr;
            cnt <= '0;
            if (found) begin
              grant     <= win_oh;
              grant_idx <= win;
              valid     <= 1'b1;
            end else begin
              grant     <= '0;
              grant_idx <= '0;
              valid     <= 1'b0;
              state     <= IDLE;
            end
          end else if ((MAX_HOLD != 0) && (cnt != HOLD_LAST)) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
